// File: rtl/comp_pkg.sv
// Shared types and constants for the digit-serial magnitude comparator.
package comp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [1:0] ResEq = 2'd0;
    localparam logic [1:0] ResGt = 2'd1;
    localparam logic [1:0] ResLt = 2'd2;

    localparam int unsigned MATCH_CNT_W = 8;

endpackage

// File: rtl/digit_cmp.sv
// Combinational compare of one DIGIT-bit slice of each operand.
module digit_cmp #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             eq_o,
    output logic             gt_o
);

    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i > b_i);

endmodule

// File: rtl/mag_comp_serial.sv
// Digit-serial EQ/GT/LT comparator, MSB digit first, with a saturating equal-result counter.
// Define MAG_COMP_EARLY_TERM_EN to finish on the first differing digit.
module mag_comp_serial
    import comp_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGIT  = 4,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [WIDTH-1:0]       a_i,
    input  logic [WIDTH-1:0]       b_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   eq_o,
    output logic                   gt_o,
    output logic                   lt_o,
    output logic [MATCH_CNT_W-1:0] match_cnt_o
);

    localparam int unsigned D    = WIDTH / DIGIT;
    localparam int unsigned CntW = $clog2(D + 1);
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] SignFlip = SIGNED ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
    localparam logic [MATCH_CNT_W-1:0] MatchMax = '1;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [1:0]             res_q, res_d;
    logic                   eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
    logic [MATCH_CNT_W-1:0] match_q, match_d;

    logic       dig_eq, dig_gt, fin;
    logic [1:0] dig_res;

    digit_cmp #(
        .DIGIT(DIGIT)
    ) u_digit_cmp (
        .a_i  (a_q[WIDTH-1 -: DIGIT]),
        .b_i  (b_q[WIDTH-1 -: DIGIT]),
        .eq_o (dig_eq),
        .gt_o (dig_gt)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        match_d = match_q;
        dig_res = res_q;
        fin     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    a_d     = a_i ^ SignFlip;
                    b_d     = b_i ^ SignFlip;
                    cnt_d   = CntW'(D);
                    res_d   = ResEq;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                end
            end
            StRun: begin
                // Only the most significant differing digit decides the order.
                if (res_q == ResEq && !dig_eq) begin
                    dig_res = dig_gt ? ResGt : ResLt;
                end
                res_d = dig_res;
                a_d   = a_q << DIGIT;
                b_d   = b_q << DIGIT;
                cnt_d = cnt_q - CntW'(1);
                fin   = (cnt_q == CntW'(1));
`ifdef MAG_COMP_EARLY_TERM_EN
                if (dig_res != ResEq) begin
                    fin = 1'b1;
                end
`endif
                if (fin) begin
                    state_d = StDone;
                    eq_d    = (dig_res == ResEq);
                    gt_d    = (dig_res == ResGt);
                    lt_d    = (dig_res == ResLt);
                    if (dig_res == ResEq && match_q != MatchMax) begin
                        match_d = match_q + MATCH_CNT_W'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res_q   <= ResEq;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            match_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            match_q <= match_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign eq_o        = eq_q;
    assign gt_o        = gt_q;
    assign lt_o        = lt_q;
    assign match_cnt_o = match_q;

endmodule

// File: tb/tb_mag_comp_serial.sv
// Directed bench for mag_comp_serial: an unsigned and a signed instance share the stimulus.
module tb_mag_comp_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a_in, b_in;

    logic       busy_u, done_u, eq_u, gt_u, lt_u;
    logic [7:0] mc_u;
    logic       busy_s, done_s, eq_s, gt_s, lt_s;
    logic [7:0] mc_s;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    int seen;

    localparam int FlEq = 4;
    localparam int FlGt = 2;
    localparam int FlLt = 1;
`ifdef MAG_COMP_EARLY_TERM_EN
    localparam int LatFirst = 1;
`else
    localparam int LatFirst = 4;
`endif

    always #5 clk = ~clk;

    mag_comp_serial #(
        .WIDTH  (16),
        .DIGIT  (4),
        .SIGNED (1'b0)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .a_i         (a_in),
        .b_i         (b_in),
        .busy_o      (busy_u),
        .done_o      (done_u),
        .eq_o        (eq_u),
        .gt_o        (gt_u),
        .lt_o        (lt_u),
        .match_cnt_o (mc_u)
    );

    mag_comp_serial #(
        .WIDTH  (16),
        .DIGIT  (4),
        .SIGNED (1'b1)
    ) u_dut_s (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .a_i         (a_in),
        .b_i         (b_in),
        .busy_o      (busy_s),
        .done_o      (done_s),
        .eq_o        (eq_s),
        .gt_o        (gt_s),
        .lt_o        (lt_s),
        .match_cnt_o (mc_s)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after the edge that re-enters IDLE.
    task automatic do_cmp(input logic [15:0] a, input logic [15:0] b, output int l);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", int'(busy_u), 1);
        check("flags_cleared", int'({eq_u, gt_u, lt_u}), 0);
        l = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done_u) begin
                l = i;
                break;
            end
        end
        check("done_seen", int'(l != -1), 1);
        if (l != -1) begin
            @(posedge clk); #1;
            check("done_one_cycle", int'(done_u), 0);
            check("busy_fall", int'(busy_u), 0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", int'(busy_u), 0);
        check("rst_done", int'(done_u), 0);
        check("rst_flags", int'({eq_u, gt_u, lt_u}), 0);
        check("rst_mc", int'(mc_u), 0);

        do_cmp(16'h9009, 16'h9009, lat);
        check("eq9009_lat", lat, 4);
        check("eq9009_flags", int'({eq_u, gt_u, lt_u}), FlEq);
        check("eq9009_mc", int'(mc_u), 1);
        do_cmp(16'h0000, 16'h0000, lat);
        check("eq0000_flags", int'({eq_u, gt_u, lt_u}), FlEq);
        do_cmp(16'hFFFF, 16'hFFFF, lat);
        check("eqFFFF_flags", int'({eq_u, gt_u, lt_u}), FlEq);
        check("eq_mc3", int'(mc_u), 3);

        do_cmp(16'h1234, 16'h1235, lat);
        check("lt1234_lat", lat, 4);
        check("lt1234_flags", int'({eq_u, gt_u, lt_u}), FlLt);
        check("lt1234_s_flags", int'({eq_s, gt_s, lt_s}), FlLt);

        do_cmp(16'hA000, 16'h5000, lat);
        check("gtA000_lat", lat, LatFirst);
        check("gtA000_flags", int'({eq_u, gt_u, lt_u}), FlGt);
        check("gtA000_mc", int'(mc_u), 3);

        do_cmp(16'hFFFF, 16'h0001, lat);
        check("ffff_u_flags", int'({eq_u, gt_u, lt_u}), FlGt);
        check("ffff_s_flags", int'({eq_s, gt_s, lt_s}), FlLt);
        do_cmp(16'h8000, 16'h7FFF, lat);
        check("8000_u_flags", int'({eq_u, gt_u, lt_u}), FlGt);
        check("8000_s_flags", int'({eq_s, gt_s, lt_s}), FlLt);

        // New start pulsed while busy must not disturb the running compare.
        start = 1'b1;
        a_in  = 16'h1234;
        b_in  = 16'h1235;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        a_in  = 16'hFFFF;
        b_in  = 16'h0000;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = -1;
        for (int i = 3; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done_u) begin
                lat = i;
                break;
            end
        end
        check("busy_start_lat", lat, 4);
        check("busy_start_flags", int'({eq_u, gt_u, lt_u}), FlLt);
        @(posedge clk); #1;
        check("busy_start_idle", int'(busy_u), 0);

        // Reset mid-compare: back to IDLE with no done pulse.
        start = 1'b1;
        a_in  = 16'h1234;
        b_in  = 16'h1235;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", int'(busy_u), 0);
        check("midrst_done", int'(done_u), 0);
        check("midrst_flags", int'({eq_u, gt_u, lt_u}), 0);
        check("midrst_mc", int'(mc_u), 0);
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done_u) seen = 1;
        end
        check("midrst_no_done", seen, 0);

        for (int k = 1; k <= 257; k++) begin
            do_cmp(16'h5A5A, 16'h5A5A, lat);
            if (k == 254) check("sat_mc254", int'(mc_u), 254);
            if (k == 255) check("sat_mc255", int'(mc_u), 255);
            if (k == 256) check("sat_mc256", int'(mc_u), 255);
            if (k == 257) check("sat_mc257", int'(mc_u), 255);
        end
        check("sat_flags", int'({eq_u, gt_u, lt_u}), FlEq);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
